// File: rtl/scad_pkg.sv
// scad_pkg: shared definitions for the SCAD shift-count / exponent stage.
//   WIDTH_DEFAULT : default SCAD datapath width (bit 0 is MSB/sign).
//   scState_t     : shift sequencer states.
//   scadWord_t    : one SCAD word, big-endian.
package scad_pkg;

  localparam int WIDTH_DEFAULT = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } scState_t;

  typedef bit [0:WIDTH_DEFAULT-1] scadWord_t;

endpackage

// File: rtl/scad_shift_seq.sv
// scad_shift_seq: SC register plus the sequencer that walks SC toward zero,
// issuing one shift step per unstalled cycle.
//   clk, rst_n  : clock, async active-low reset
//   scadF       : SCAD ALU result (two's complement, bit 0 = sign)
//   scLoad      : load SC from scadF (IDLE/DONE only)
//   scClear     : clear SC (IDLE/DONE only, beats scLoad)
//   shiftStart  : start a sequence from IDLE using the current SC
//   shiftStall  : hold the sequence this cycle
//   SC          : shift counter register
//   shiftStep   : shift one place this cycle
//   shiftRight  : step direction, 1 = right (SC negative)
//   busy        : in SHIFT
//   done        : one-cycle completion pulse
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting; SC accepts load/clear, shiftStart begins a sequence
// SHIFT | stepping SC toward zero, one step per unstalled cycle
// DONE  | SC reached zero; done pulses for one cycle; SC load/clear ok
module scad_shift_seq
  import scad_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [0:WIDTH-1] scadF,
  input  logic             scLoad,
  input  logic             scClear,
  input  logic             shiftStart,
  input  logic             shiftStall,
  output logic [0:WIDTH-1] SC,
  output logic             shiftStep,
  output logic             shiftRight,
  output logic             busy,
  output logic             done
);

  localparam logic [0:WIDTH-1] SC_ZERO = '0;
  localparam logic [0:WIDTH-1] SC_ONE  = WIDTH'(1);

  scState_t         state_q, state_nxt;
  logic [0:WIDTH-1] sc_q, sc_nxt;
  logic             step;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sc_q    <= SC_ZERO;
    end else begin
      state_q <= state_nxt;
      sc_q    <= sc_nxt;
    end
  end

  always_comb begin
    state_nxt = state_q;
    sc_nxt    = sc_q;
    step      = 1'b0;
    unique case (state_q)
      IDLE: begin
        // A load or clear in the same cycle as shiftStart wins and the
        // start is dropped, so the sequence never runs on a stale count.
        if (scClear) begin
          sc_nxt = SC_ZERO;
        end else if (scLoad) begin
          sc_nxt = scadF;
        end else if (shiftStart) begin
          state_nxt = (sc_q == SC_ZERO) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        if (!shiftStall) begin
          step = 1'b1;
          // Always move toward zero: -2^(WIDTH-1) counts up and cannot wrap.
          sc_nxt = sc_q[0] ? (sc_q + SC_ONE) : (sc_q - SC_ONE);
          if (sc_nxt == SC_ZERO) begin
            state_nxt = DONE;
          end
        end
      end
      DONE: begin
        state_nxt = IDLE;
        if (scClear) begin
          sc_nxt = SC_ZERO;
        end else if (scLoad) begin
          sc_nxt = scadF;
        end
      end
      default: begin
        state_nxt = IDLE;
        sc_nxt    = SC_ZERO;
      end
    endcase
  end

  assign SC         = sc_q;
  assign shiftStep  = step;
  assign shiftRight = sc_q[0];
  assign busy       = (state_q == SHIFT);
  assign done       = (state_q == DONE);

endmodule

// File: rtl/scad_sc_fe.sv
// scad_sc_fe: SC / FE register stage behind the SCAD ALU. SC and its shift
// sequencer live in scad_shift_seq; FE is a plain load/clear register.
//   clk, rst_n          : clock, async active-low reset
//   scadF               : SCAD ALU result
//   scLoad, scClear     : SC load / clear (ignored while shifting)
//   feLoad, feClear     : FE load / clear (any state, clear wins)
//   shiftStart          : begin shift sequence
//   shiftStall          : hold sequence this cycle
//   SC, FE              : registers fed back to the SCAD A/B muxes
//   scSign, scZero      : SC sign bit and zero flag
//   shiftStep           : shift AR/BR one place this cycle
//   shiftRight          : step direction, 1 = right
//   busy, done          : sequencer in SHIFT / completion pulse
module scad_sc_fe
  import scad_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [0:WIDTH-1] scadF,
  input  logic             scLoad,
  input  logic             scClear,
  input  logic             feLoad,
  input  logic             feClear,
  input  logic             shiftStart,
  input  logic             shiftStall,
  output logic [0:WIDTH-1] SC,
  output logic [0:WIDTH-1] FE,
  output logic             scSign,
  output logic             scZero,
  output logic             shiftStep,
  output logic             shiftRight,
  output logic             busy,
  output logic             done
);

  logic [0:WIDTH-1] fe_q;
  logic [0:WIDTH-1] sc_w;

  scad_shift_seq #(
    .WIDTH(WIDTH)
  ) u_seq (
    .clk        (clk),
    .rst_n      (rst_n),
    .scadF      (scadF),
    .scLoad     (scLoad),
    .scClear    (scClear),
    .shiftStart (shiftStart),
    .shiftStall (shiftStall),
    .SC         (sc_w),
    .shiftStep  (shiftStep),
    .shiftRight (shiftRight),
    .busy       (busy),
    .done       (done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fe_q <= '0;
    end else if (feClear) begin
      fe_q <= '0;
    end else if (feLoad) begin
      fe_q <= scadF;
    end
  end

  assign SC     = sc_w;
  assign FE     = fe_q;
  assign scSign = sc_w[0];
  assign scZero = (sc_w == '0);

endmodule

// File: doc/scad_sc_fe.md
# scad_sc_fe

Shift-count / floating-exponent register stage directly downstream of the three-slice 10-bit SCAD ALU. It captures the ALU result `scadF` into the SC (shift counter) and FE (floating exponent) registers. It then runs SC as a signed up/down step counter that paces the main shifter, issuing one step pulse per cycle until SC reaches zero. SC and FE are driven back to the SCAD A/B input muxes.

## Interface
Parameters:
- `WIDTH`, default 10: SCAD datapath width. Bit 0 is MSB/sign; all vectors are `[0:WIDTH-1]`, big-endian.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `scadF`  in  WIDTH  SCAD ALU result, two's complement.
- `scLoad`  in  1  load SC from `scadF`.
- `scClear`  in  1  clear SC to 0.
- `feLoad`  in  1  load FE from `scadF`.
- `feClear`  in  1  clear FE to 0.
- `shiftStart`  in  1  begin a shift sequence using the current SC.
- `shiftStall`  in  1  hold the sequence this cycle, e.g. for a memory wait.
- `SC`  out  WIDTH  shift counter register.
- `FE`  out  WIDTH  floating exponent register.
- `scSign`  out  1  `SC[0]`.
- `scZero`  out  1  SC == 0.
- `shiftStep`  out  1  shift AR/BR one place this cycle.
- `shiftRight`  out  1  direction of `shiftStep`: 1 = right (SC negative), 0 = left.
- `busy`  out  1  sequencer is in the SHIFT state.
- `done`  out  1  one-cycle completion pulse.

## Operation
- States: IDLE, SHIFT, DONE. Reset puts the block in IDLE with SC=0, FE=0, `done`=0.
- FE behaviour, in any state:
  - `feClear` has priority over `feLoad`.
  - Otherwise `feLoad` loads `scadF`.
  - Otherwise FE holds.
- SC behaviour in IDLE:
  - `scClear` has priority over `scLoad`.
  - `scLoad` loads `scadF`.
  - If `scClear` or `scLoad` is asserted together with `shiftStart`, the load/clear wins and `shiftStart` is ignored.
- IDLE, `shiftStart` alone:
  - SC == 0: go to DONE. No steps are issued.
  - SC ≠ 0: go to SHIFT.
- SHIFT state:
  - `shiftStall`=1: SC holds and `shiftStep`=0.
  - `shiftStall`=0: `shiftStep`=1 and SC moves one toward zero. SC is incremented when `SC[0]`=1 and decremented otherwise.
  - When the updated SC equals 0, go to DONE.
  - Number of steps equals |SC at start|. SC = -2^(WIDTH-1) (-512) produces 512 right steps; no overflow is possible because the count moves toward zero.
- In SHIFT, `scLoad`, `scClear` and `shiftStart` are ignored because the sequencer owns SC. `feLoad`/`feClear` still act.
- DONE: `done`=1 for exactly one cycle, then IDLE. SC=0 in DONE. SC load/clear are accepted in DONE exactly as in IDLE. `shiftStart` in DONE is ignored.
- `shiftRight` = `SC[0]`; it is valid only while `shiftStep`=1.
- `rst_n` low in any state immediately forces IDLE, SC=0, FE=0, and `done`=`busy`=`shiftStep`=0.

## Timing
- SC, FE and state are registered. They update on the rising `clk` after the request.
- Load latency is 1 cycle: `scLoad` in cycle N makes `SC`=`scadF` visible in cycle N+1.
- `busy` = (state==SHIFT). It rises the cycle after an accepted `shiftStart`.
- `shiftStep` is combinational from state and `shiftStall`: (state==SHIFT) & ~`shiftStall`. The consumer samples it on the same edge that updates SC.
- Unstalled sequence for SC=k≠0:
  - `shiftStart` in cycle N.
  - Steps in cycles N+1 .. N+|k|.
  - `done` in cycle N+|k|+1.
  - Each stalled cycle adds one.
- Sequence for SC=0: `shiftStart` in N, `done` in N+1.
- `scZero` and `scSign` are combinational from the SC register.

## Structure
- Package `scad_pkg` holds `WIDTH_DEFAULT`=10, `typedef enum {IDLE, SHIFT, DONE} scState_t`, and the `scadWord_t` typedef (`bit [0:9]`).
- Sub-module `scad_shift_seq` holds the state machine plus the SC register and its up/down step logic.
- The top level `scad_sc_fe` instantiates `scad_shift_seq` and contains the FE register.

## Test plan
- Load SC with `scadF`=10'd5, then `shiftStart` → 5 `shiftStep` cycles with `shiftRight`=0; SC goes 4,3,2,1,0; `done` pulses in cycle 6; `busy` drops.
- Load SC with -3 (10'b1111111101), then `shiftStart` with `shiftStall` high on the 2nd step cycle → 3 steps with `shiftRight`=1 over 4 SHIFT cycles; SC holds -2 during the stall; final SC=0.
- SC=0, `shiftStart` → no `shiftStep`; `done` the next cycle; SC stays 0.
- SC=-512, `shiftStart` → exactly 512 right steps, then `done`; no wrap past 0.
- Mid-SHIFT (SC=7, started at 10): `scLoad`=1 with `scadF`=99 has no effect on SC; `feLoad` with 99 sets FE=99 the next cycle; `feClear`+`feLoad` together → FE=0.
- `rst_n` low during SHIFT (SC=3) → immediately SC=0, FE=0, `busy`=0, `shiftStep`=0, no `done`; after release, IDLE accepts `scLoad` on the first edge.
